pingpong_weight_scheduler: RTL and testbench
============================================

Name: pingpong_weight_scheduler

Overview:
- Controller for the neuron's two weight SRAM banks (ping-pong) and the MAC accumulator.
- A weight loader fills one bank through a valid/ready handshake while the MAC reads the other bank.
- Each read pass covers a full bank and drives the accumulator clear/enable.
- Banks swap only when a fill or a pass completes. No weight data passes through this block: it produces addresses, enables and status only.

Parameters:
ADDR_W, 4, bank address width; DEPTH = 2**ADDR_W weights per bank
RD_LAT, 1, SRAM read latency in cycles from sram_re to valid read data

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  loader presents a weight this cycle
wr_ready  out  1  scheduler can accept a weight (fill bank free)
rd_start  in  1  single-cycle request for one read pass
rd_busy  out  1  read pass in progress
rd_done  out  1  single-cycle pulse, pass complete
sram_we  out  2  per-bank write enable (bit0 = bank0)
sram_waddr  out  ADDR_W  write address
sram_re  out  2  per-bank read enable
sram_raddr  out  ADDR_W  read address
mux_select  out  1  bank whose read data feeds the MAC
acc_clear  out  1  clear accumulator, coincident with first acc_en of a pass
acc_en  out  1  accumulate current product
bank_full  out  2  per-bank FULL status

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: both banks EMPTY; fbank=0, rbank=0, fcount=0, rcount=0; pending=0; read FSM in IDLE. All outputs 0, except wr_ready=1.
- Per-bank state: EMPTY, FILLING, FULL or READING. bank_full[i] is 1 only when bank i is FULL.
- Write path (combinational from registered state):
  - wr_ready = state[fbank] is EMPTY or FILLING.
  - sram_we[fbank] = wr_valid & wr_ready; sram_waddr = fcount.
- Write handshake (wr_valid & wr_ready):
  - fcount increments; state[fbank] becomes FILLING.
  - If fcount was DEPTH-1, then at that edge: state[fbank] becomes FULL, fcount wraps to 0, fbank toggles.
- Fill stall: wr_ready stays 0 while the next fill bank is FULL or READING. Writes never target a bank that is FULL or READING.
- Read FSM states: IDLE, READ, DRAIN.
- IDLE:
  - rd_start while IDLE sets pending.
  - When (rd_start | pending) and state[rbank]==FULL: go to READ, set state[rbank]=READING, rcount=0, clear pending.
- READ (registered outputs):
  - sram_re[rbank]=1, sram_raddr=rcount, mux_select=rbank; rcount increments.
  - After the cycle with raddr=DEPTH-1, go to DRAIN.
- acc_en timing: acc_en is the sram_re-active indicator delayed RD_LAT cycles. acc_clear is asserted with the first acc_en of a pass only.
- DRAIN: lasts RD_LAT cycles until the last acc_en has been issued. Then:
  - rd_done pulses for 1 cycle.
  - state[rbank]=EMPTY, rbank toggles, FSM returns to IDLE.
- Pass timing with rd_start at cycle T and bank FULL:
  - sram_re active T+1..T+DEPTH.
  - acc_en active T+1+RD_LAT..T+DEPTH+RD_LAT.
  - rd_done at T+DEPTH+RD_LAT+1.
  - rd_busy high from T+1 through the cycle before rd_done.
- Bank becoming FULL with a request pending: bank FULL at edge E, READ entered at edge E+1.
- rd_start during READ/DRAIN: ignored, not latched. rd_start while pending: no effect.
- Released bank: EMPTY is visible the cycle rd_done is high, so wr_ready may rise that cycle.
- Simultaneous fill and read: always on different banks by construction. Both proceed in the same cycle.
- Reset mid-fill or mid-pass: immediate return to reset values. Partially written data is discarded (bank EMPTY). No rd_done is issued.

Optional Feature:
PP_STALL_CNT_EN:
- Defined: adds output stall_cnt, 16 bits.
  - Increments each cycle the FSM is IDLE with pending=1 (or rd_start=1) while state[rbank]!=FULL.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- ADDR_W=2, RD_LAT=1, reset, 4 back-to-back writes -> sram_we=2'b01 with waddr 0,1,2,3; then bank_full=2'b01, fbank=1, wr_ready stays 1.
- 8 writes, then wr_valid held -> bank_full=2'b11, wr_ready=0. Then rd_start at T -> sram_re=2'b01 with raddr 0..3 at T+1..T+4, acc_clear&acc_en at T+2, acc_en T+2..T+5, rd_done at T+6, wr_ready=1 at T+6, next write to bank0 addr 0.
- rd_start with both banks EMPTY, then 4 writes ending at cycle C -> pending held, READ entered so sram_re=2'b01 at C+2, full pass on bank0.
- Concurrent: bank0 FULL, bank1 being filled during the bank0 pass -> sram_we[1] and sram_re[0] active in the same cycles. The second pass uses mux_select=1.
- rd_start pulsed during READ -> ignored, exactly one rd_done. Reset asserted mid-pass at raddr=2 -> all outputs 0 the same cycle, wr_ready=1, bank_full=2'b00.
- PP_STALL_CNT_EN: rd_start with empty banks, then 10 idle cycles -> stall_cnt=10 before any write.

Source files
------------

// File: rtl/pingpong_weight_scheduler.sv
// rtl/pingpong_weight_scheduler.sv - ping-pong weight bank scheduler (optional PP_STALL_CNT_EN adds stall_cnt)
module pingpong_weight_scheduler #(
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_start,
    output logic              rd_busy,
    output logic              rd_done,
    output logic [1:0]        sram_we,
    output logic [ADDR_W-1:0] sram_waddr,
    output logic [1:0]        sram_re,
    output logic [ADDR_W-1:0] sram_raddr,
    output logic              mux_select,
    output logic              acc_clear,
    output logic              acc_en,
    output logic [1:0]        bank_full
`ifdef PP_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_t;
    typedef enum logic [1:0] {RS_IDLE, RS_READ, RS_DRAIN} rd_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam int                DC_W       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DC_W-1:0]   DRAIN_LAST = DC_W'(RD_LAT - 1);

    bank_state_t       bank_q [2];
    bank_state_t       bank_d [2];
    rd_state_t         rd_state_q, rd_state_d;
    logic              fbank_q, fbank_d;
    logic              rbank_q, rbank_d;
    logic [ADDR_W-1:0] fcount_q, fcount_d;
    logic [ADDR_W-1:0] rcount_q, rcount_d;
    logic              pending_q, pending_d;
    logic              re_active_q, re_active_d;
    logic              mux_q, mux_d;
    logic              rd_done_q, rd_done_d;
    logic [DC_W-1:0]   dcount_q, dcount_d;
    logic [RD_LAT-1:0] en_pipe_q, en_pipe_d;
    logic [RD_LAT-1:0] clr_pipe_q, clr_pipe_d;
    logic              wr_fire;

    assign wr_ready   = (bank_q[fbank_q] == B_EMPTY) || (bank_q[fbank_q] == B_FILLING);
    assign wr_fire    = wr_valid && wr_ready;
    assign sram_we    = wr_fire ? (fbank_q ? 2'b10 : 2'b01) : 2'b00;
    assign sram_waddr = fcount_q;
    assign sram_re    = re_active_q ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;
    assign sram_raddr = rcount_q;
    assign mux_select = mux_q;
    assign acc_en     = en_pipe_q[RD_LAT-1];
    assign acc_clear  = clr_pipe_q[RD_LAT-1];
    assign rd_busy    = (rd_state_q != RS_IDLE);
    assign rd_done    = rd_done_q;
    assign bank_full  = {bank_q[1] == B_FULL, bank_q[0] == B_FULL};

    // next state for read FSM, bank ownership and fill pointer; read side first, fill side last (always different banks)
    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        fbank_d     = fbank_q;
        fcount_d    = fcount_q;
        rd_state_d  = rd_state_q;
        rbank_d     = rbank_q;
        rcount_d    = rcount_q;
        pending_d   = pending_q;
        re_active_d = re_active_q;
        mux_d       = mux_q;
        dcount_d    = dcount_q;
        rd_done_d   = 1'b0;
        en_pipe_d   = RD_LAT'({en_pipe_q, re_active_q});
        clr_pipe_d  = RD_LAT'({clr_pipe_q, re_active_q && (rcount_q == '0)});

        case (rd_state_q)
            RS_IDLE: begin
                if ((rd_start || pending_q) && (bank_q[rbank_q] == B_FULL)) begin
                    rd_state_d      = RS_READ;
                    bank_d[rbank_q] = B_READING;
                    rcount_d        = '0;
                    re_active_d     = 1'b1;
                    mux_d           = rbank_q;
                    pending_d       = 1'b0;
                end else if (rd_start) begin
                    pending_d = 1'b1;
                end
            end
            RS_READ: begin
                rcount_d = rcount_q + 1'b1;
                if (rcount_q == LAST_ADDR) begin
                    re_active_d = 1'b0;
                    dcount_d    = '0;
                    rd_state_d  = RS_DRAIN;
                end
            end
            RS_DRAIN: begin
                if (dcount_q == DRAIN_LAST) begin
                    rd_state_d      = RS_IDLE;
                    rd_done_d       = 1'b1;
                    bank_d[rbank_q] = B_EMPTY;
                    rbank_d         = ~rbank_q;
                end else begin
                    dcount_d = dcount_q + 1'b1;
                end
            end
            default: rd_state_d = RS_IDLE;
        endcase

        if (wr_fire) begin
            bank_d[fbank_q] = B_FILLING;
            fcount_d        = fcount_q + 1'b1;
            if (fcount_q == LAST_ADDR) begin
                bank_d[fbank_q] = B_FULL;
                fbank_d         = ~fbank_q;
            end
        end
    end

    // state registers, cleared asynchronously so a reset mid-pass drops everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q[0]   <= B_EMPTY;
            bank_q[1]   <= B_EMPTY;
            rd_state_q  <= RS_IDLE;
            fbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            fcount_q    <= '0;
            rcount_q    <= '0;
            pending_q   <= 1'b0;
            re_active_q <= 1'b0;
            mux_q       <= 1'b0;
            rd_done_q   <= 1'b0;
            dcount_q    <= '0;
            en_pipe_q   <= '0;
            clr_pipe_q  <= '0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            rd_state_q  <= rd_state_d;
            fbank_q     <= fbank_d;
            rbank_q     <= rbank_d;
            fcount_q    <= fcount_d;
            rcount_q    <= rcount_d;
            pending_q   <= pending_d;
            re_active_q <= re_active_d;
            mux_q       <= mux_d;
            rd_done_q   <= rd_done_d;
            dcount_q    <= dcount_d;
            en_pipe_q   <= en_pipe_d;
            clr_pipe_q  <= clr_pipe_d;
        end
    end

`ifdef PP_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    assign stall_cnt = stall_q;

    // count cycles a read request waits on a bank that is not yet full, saturating
    always_comb begin
        stall_d = stall_q;
        if ((rd_state_q == RS_IDLE) && (pending_q || rd_start) &&
            (bank_q[rbank_q] != B_FULL) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_weight_scheduler.sv
// tb/tb_pingpong_weight_scheduler.sv - directed timing checks plus randomized scoreboard for pingpong_weight_scheduler
module tb_pingpong_weight_scheduler;

    localparam int ADDR_W = 2;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 4;
    localparam int NP     = 6;
    localparam int NW     = NP * DEPTH;

    logic              clk;
    logic              reset;
    logic              wr_valid;
    logic              wr_ready;
    logic              rd_start;
    logic              rd_busy;
    logic              rd_done;
    logic [1:0]        sram_we;
    logic [ADDR_W-1:0] sram_waddr;
    logic [1:0]        sram_re;
    logic [ADDR_W-1:0] sram_raddr;
    logic              mux_select;
    logic              acc_clear;
    logic              acc_en;
    logic [1:0]        bank_full;
`ifdef PP_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    logic       sb_en = 1'b0;
    logic [3:0] exp_wr [$];
    logic [4:0] exp_rd [$];
    logic       exp_acc [$];
    int         exp_done [$];
    int         wr_seen = 0;
    int         rd_seen = 0;
    int         acc_seen = 0;
    int         done_seen = 0;
    int         mp;

    pingpong_weight_scheduler #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_start   (rd_start),
        .rd_busy    (rd_busy),
        .rd_done    (rd_done),
        .sram_we    (sram_we),
        .sram_waddr (sram_waddr),
        .sram_re    (sram_re),
        .sram_raddr (sram_raddr),
        .mux_select (mux_select),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
`ifdef PP_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .bank_full  (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got missing/unexpected event, required expected event", name);
    endtask

    function automatic logic [15:0] outv();
        return {sram_we, sram_waddr, sram_re, sram_raddr, mux_select, acc_clear, acc_en,
                rd_busy, rd_done, bank_full, wr_ready};
    endfunction

    function automatic logic [15:0] mkv(input logic [1:0] we, input logic [1:0] wa,
                                        input logic [1:0] re, input logic [1:0] ra,
                                        input logic mux, input logic clr, input logic en,
                                        input logic busy, input logic done,
                                        input logic [1:0] full, input logic rdy);
        return {we, wa, re, ra, mux, clr, en, busy, done, full, rdy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        rd_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            seen = rd_done;
            tick();
        end
    endtask

    // scoreboard monitor: pops expected events whenever the DUT shows a write, read, accumulate or done
    always @(negedge clk) begin
        if (sb_en && !reset) begin
            if (rd_done) begin
                if (exp_done.size() == 0) begin
                    fail_now("sb_done_extra");
                end else begin
                    mp = exp_done.pop_front();
                    check("sb_done_accs", acc_seen, (mp + 1) * DEPTH);
                    check("sb_done_busy", rd_busy, 0);
                end
                done_seen++;
            end
            if (sram_we != 2'b00) begin
                if (wr_seen >= 2 * DEPTH)
                    check("sb_refill_after_release", done_seen >= (wr_seen / DEPTH - 1), 1);
                if (exp_wr.size() == 0) fail_now("sb_wr_extra");
                else check("sb_wr", {sram_we, sram_waddr}, exp_wr.pop_front());
                wr_seen++;
            end
            if (sram_re != 2'b00) begin
                if (sram_raddr == 0)
                    check("sb_fill_before_read", wr_seen >= (rd_seen / DEPTH + 1) * DEPTH, 1);
                if (exp_rd.size() == 0) fail_now("sb_rd_extra");
                else check("sb_rd", {sram_re, sram_raddr, mux_select}, exp_rd.pop_front());
                rd_seen++;
            end
            if (acc_en) begin
                if (exp_acc.size() == 0) fail_now("sb_acc_extra");
                else check("sb_acc_clear", acc_clear, exp_acc.pop_front());
                acc_seen++;
            end else if (acc_clear) begin
                fail_now("sb_clear_without_en");
            end
        end
    end

    initial begin
        bit seen;
        int dcnt;

        reset    = 1'b1;
        wr_valid = 1'b0;
        rd_start = 1'b0;
        @(negedge clk);
        check("reset_outputs", outv(), mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // first fill lands in bank0, addresses 0..3
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("fill0_we", {sram_we, sram_waddr, wr_ready}, {2'b01, 2'(i), 1'b1});
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        check("fill0_done", {bank_full, wr_ready, sram_we}, {2'b01, 1'b1, 2'b00});
        tick();

        // second fill lands in bank1, then the loader stalls
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("fill1_we", {sram_we, sram_waddr, wr_ready}, {2'b10, 2'(i), 1'b1});
            tick();
        end
        @(negedge clk);
        check("both_full_stall", {bank_full, wr_ready, sram_we}, {2'b11, 1'b0, 2'b00});
        tick();

        // pass timing relative to rd_start cycle T=0, loader still holding wr_valid
        rd_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("pass_cycle_%0d", k), outv(),
                  mkv((k >= 6) ? 2'b01 : 2'b00,
                      (k >= 6) ? 2'(k - 6) : 2'd0,
                      (k >= 1 && k <= DEPTH) ? 2'b01 : 2'b00,
                      (k >= 1 && k <= DEPTH) ? 2'(k - 1) : 2'd0,
                      1'b0,
                      k == 2,
                      k >= 2 && k <= DEPTH + 1,
                      k >= 1 && k <= DEPTH + 1,
                      k == DEPTH + 2,
                      (k == 0) ? 2'b11 : 2'b10,
                      k >= 6));
            tick();
            rd_start = 1'b0;
        end
        wr_valid = 1'b0;

        // request with empty banks stays pending until bank0 fills
        do_reset();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (9) tick();
        @(negedge clk);
`ifdef PP_STALL_CNT_EN
        check("stall_cnt_10", stall_cnt, 10);
`endif
        check("pending_idle", {rd_busy, sram_re}, {1'b0, 2'b00});
        tick();
        wr_valid = 1'b1;
        repeat (DEPTH) tick();
        wr_valid = 1'b0;
        @(negedge clk);
        check("pending_c1", {sram_re, bank_full, rd_busy}, {2'b00, 2'b01, 1'b0});
        tick();
        @(negedge clk);
        check("pending_c2", {sram_re, sram_raddr, mux_select, rd_busy}, {2'b01, 2'd0, 1'b0, 1'b1});
        wait_done(20, seen);
        check("pending_pass_done", seen, 1);

        // concurrent fill of bank1 while bank0 is read
        do_reset();
        wr_valid = 1'b1;
        repeat (DEPTH) tick();
        rd_start = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            if (k == 1)
                check("concurrent_we_re", {sram_we, sram_re, sram_waddr, sram_raddr},
                      {2'b10, 2'b01, 2'd1, 2'd0});
            tick();
            rd_start = 1'b0;
        end
        wr_valid = 1'b0;
        wait_done(20, seen);
        check("concurrent_pass0_done", seen, 1);

        // second pass reads bank1; a rd_start during READ is ignored
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        @(negedge clk);
        check("pass1_bank1", {sram_re, sram_raddr, mux_select}, {2'b10, 2'd0, 1'b1});
        tick();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rd_done) dcnt++;
            tick();
        end
        check("single_done", dcnt, 1);
        wr_valid = 1'b1;
        repeat (DEPTH) tick();
        wr_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("ignored_start_not_latched", {rd_busy, bank_full}, {1'b0, 2'b01});
        tick();

        // reset asserted mid-pass at raddr=2
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        #1;
        check("midpass_raddr2", {sram_re, sram_raddr}, {2'b01, 2'd2});
        reset = 1'b1;
        #1;
        check("midpass_reset_outputs", outv(), mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_done) dcnt++;
            tick();
        end
        check("midpass_no_done", {dcnt[3:0], bank_full}, {4'd0, 2'b00});

        // randomized concurrent traffic against the scoreboard
        do_reset();
        sb_en = 1'b1;
        fork
            begin : writer
                bit accepted;
                bit stop;
                stop = 1'b0;
                for (int k = 0; k < NW && !stop; k++) begin
                    exp_wr.push_back({(((k / DEPTH) % 2) == 1) ? 2'b10 : 2'b01, 2'(k % DEPTH)});
                    repeat ($urandom_range(0, 2)) tick();
                    wr_valid = 1'b1;
                    accepted = 1'b0;
                    for (int g = 0; g < 400 && !accepted; g++) begin
                        @(negedge clk);
                        accepted = wr_ready;
                        tick();
                    end
                    wr_valid = 1'b0;
                    if (!accepted) begin
                        fail_now("rand_wr_timeout");
                        stop = 1'b1;
                    end
                end
            end
            begin : reader
                bit got;
                bit stop;
                stop = 1'b0;
                for (int p = 0; p < NP && !stop; p++) begin
                    repeat ($urandom_range(0, 20)) tick();
                    for (int a = 0; a < DEPTH; a++) begin
                        exp_rd.push_back({((p % 2) == 1) ? 2'b10 : 2'b01, 2'(a), 1'(p % 2)});
                        exp_acc.push_back(a == 0);
                    end
                    exp_done.push_back(p);
                    rd_start = 1'b1;
                    tick();
                    rd_start = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        tick();
                        rd_start = 1'b1;
                        tick();
                        rd_start = 1'b0;
                    end
                    got = 1'b0;
                    for (int g = 0; g < 400 && !got; g++) begin
                        @(negedge clk);
                        got = (done_seen >= p + 1);
                        tick();
                    end
                    if (!got) begin
                        fail_now("rand_pass_timeout");
                        stop = 1'b1;
                    end
                end
            end
        join
        repeat (10) tick();
        sb_en = 1'b0;
        check("rand_wr_drained", exp_wr.size(), 0);
        check("rand_rd_drained", exp_rd.size(), 0);
        check("rand_acc_drained", exp_acc.size(), 0);
        check("rand_done_count", done_seen, NP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
